// File: rtl/control_sequencer_if.sv
// control_sequencer_if: control bundle between control_sequencer and the alu_system datapath.
interface control_sequencer_if;
  logic [15:0] IROut;
  logic        zflag;
  logic [2:0]  state;
  logic [3:0]  RegSel_rf;
  logic [3:0]  ScrSel;
  logic [2:0]  FunSel3;
  logic [2:0]  OutASel;
  logic [2:0]  OutBSel;
  logic        MuxDSel;
  logic [4:0]  FunSel5;
  logic [1:0]  MuxCSel;
  logic        LH;
  logic        write;
  logic        E;
  logic [1:0]  FunSel2_dr;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic [1:0]  FunSel2_arf;
  logic [2:0]  RegSel_arf;
  logic [1:0]  OutCSel;
  logic [1:0]  OutDSel;
  logic        WR;
  logic        CS;
  modport master (
    input  IROut, zflag,
    output state, RegSel_rf, ScrSel, FunSel3, OutASel, OutBSel, MuxDSel, FunSel5, MuxCSel,
           LH, write, E, FunSel2_dr, MuxASel, MuxBSel, FunSel2_arf, RegSel_arf, OutCSel,
           OutDSel, WR, CS
  );
  modport slave (
    output IROut, zflag,
    input  state, RegSel_rf, ScrSel, FunSel3, OutASel, OutBSel, MuxDSel, FunSel5, MuxCSel,
           LH, write, E, FunSel2_dr, MuxASel, MuxBSel, FunSel2_arf, RegSel_arf, OutCSel,
           OutDSel, WR, CS
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control for alu_system.
module control_sequencer #(
  parameter logic [5:0] HALT_OPCODE = 6'h3F,
  parameter logic [4:0] ALU_PASS_A  = 5'b10000
) (
  input logic clock,
  input logic reset,
  control_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    INIT = 3'd0, FETCH_L = 3'd1, FETCH_H = 3'd2, DECODE = 3'd3, EXEC = 3'd4, HALT = 3'd7
  } state_t;
  state_t st;
  logic [5:0] op;
  logic [1:0] rx;
  logic init, fetch, ex, bra, ldi, inc, sto;
  assign op = bus.IROut[15:10];
  assign rx = bus.IROut[9:8];
  always_ff @(posedge clock or posedge reset)
    if (reset) st <= INIT;
    else
      case (st)
        INIT:    st <= FETCH_L;
        FETCH_L: st <= FETCH_H;
        FETCH_H: st <= DECODE;
        DECODE:  st <= (op == HALT_OPCODE) ? HALT : EXEC;
        EXEC:    st <= FETCH_L;
        HALT:    st <= HALT;
        default: st <= INIT;
      endcase
  // Reset gates every decode term so outputs go idle without waiting for a clock edge.
  assign init  = !reset && st == INIT;
  assign fetch = !reset && (st == FETCH_L || st == FETCH_H);
  assign ex    = !reset && st == EXEC;
  assign bra   = ex && (op == 6'd0 || (op == 6'd1 && !bus.zflag));
  assign ldi   = ex && op == 6'd2;
  assign inc   = ex && op == 6'd3;
  assign sto   = ex && op == 6'd4;
  assign bus.state       = st;
  assign bus.RegSel_rf   = (ldi || inc) ? 4'b0001 << rx : 4'b0000;
  assign bus.ScrSel      = 4'b0000;
  assign bus.FunSel3     = ldi ? 3'b010 : inc ? 3'b001 : 3'b000;
  assign bus.OutASel     = sto ? {1'b0, rx} : 3'b000;
  assign bus.OutBSel     = 3'b000;
  assign bus.MuxDSel     = 1'b0;
  assign bus.FunSel5     = sto ? ALU_PASS_A : 5'b00000;
  assign bus.MuxCSel     = 2'b00;
  assign bus.LH          = fetch && st == FETCH_H;
  assign bus.write       = fetch;
  assign bus.E           = 1'b0;
  assign bus.FunSel2_dr  = 2'b00;
  assign bus.MuxASel     = ldi ? 2'b11 : 2'b00;
  assign bus.MuxBSel     = bra ? 2'b11 : 2'b00;
  assign bus.FunSel2_arf = init ? 2'b11 : fetch ? 2'b01 : bra ? 2'b10 : 2'b00;
  assign bus.RegSel_arf  = (init || fetch || bra) ? 3'b100 : 3'b000;
  assign bus.OutCSel     = 2'b00;
  assign bus.OutDSel     = sto ? 2'b01 : 2'b00;
  assign bus.WR          = sto;
  assign bus.CS          = !(fetch || sto);
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench comparing every control output against a per-state model.
module tb_control_sequencer;
  typedef struct packed {
    logic [2:0] state;
    logic [3:0] regsel_rf;
    logic [3:0] scrsel;
    logic [2:0] funsel3;
    logic [2:0] outasel;
    logic [2:0] outbsel;
    logic       muxdsel;
    logic [4:0] funsel5;
    logic [1:0] muxcsel;
    logic       lh;
    logic       write;
    logic       e;
    logic [1:0] funsel2_dr;
    logic [1:0] muxasel;
    logic [1:0] muxbsel;
    logic [1:0] funsel2_arf;
    logic [2:0] regsel_arf;
    logic [1:0] outcsel;
    logic [1:0] outdsel;
    logic       wr;
    logic       cs;
  } ctl_t;
  logic clock = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  logic [2:0] ms = 3'd0;
  ctl_t got;
  ctl_t sb[$];
  control_sequencer_if bus();
  control_sequencer dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  always_comb begin
    got = '0;
    got.state = bus.state;
    got.regsel_rf = bus.RegSel_rf;
    got.scrsel = bus.ScrSel;
    got.funsel3 = bus.FunSel3;
    got.outasel = bus.OutASel;
    got.outbsel = bus.OutBSel;
    got.muxdsel = bus.MuxDSel;
    got.funsel5 = bus.FunSel5;
    got.muxcsel = bus.MuxCSel;
    got.lh = bus.LH;
    got.write = bus.write;
    got.e = bus.E;
    got.funsel2_dr = bus.FunSel2_dr;
    got.muxasel = bus.MuxASel;
    got.muxbsel = bus.MuxBSel;
    got.funsel2_arf = bus.FunSel2_arf;
    got.regsel_arf = bus.RegSel_arf;
    got.outcsel = bus.OutCSel;
    got.outdsel = bus.OutDSel;
    got.wr = bus.WR;
    got.cs = bus.CS;
  end
  function automatic ctl_t model(input logic [2:0] s, input logic [15:0] ir, input logic z, input logic r);
    ctl_t c = '0;
    c.cs = 1'b1;
    c.state = r ? 3'd0 : s;
    if (!r)
      case (s)
        3'd0: begin c.regsel_arf = 3'b100; c.funsel2_arf = 2'b11; end
        3'd1, 3'd2: begin
          c.cs = 1'b0; c.write = 1'b1; c.lh = (s == 3'd2);
          c.regsel_arf = 3'b100; c.funsel2_arf = 2'b01;
        end
        3'd4:
          case (ir[15:10])
            6'd0, 6'd1:
              if (ir[15:10] == 6'd0 || !z) begin
                c.muxbsel = 2'b11; c.regsel_arf = 3'b100; c.funsel2_arf = 2'b10;
              end
            6'd2: begin c.muxasel = 2'b11; c.funsel3 = 3'b010; c.regsel_rf[ir[9:8]] = 1'b1; end
            6'd3: begin c.funsel3 = 3'b001; c.regsel_rf[ir[9:8]] = 1'b1; end
            6'd4: begin
              c.outasel = {1'b0, ir[9:8]}; c.funsel5 = 5'b10000;
              c.outdsel = 2'b01; c.cs = 1'b0; c.wr = 1'b1;
            end
            default: ;
          endcase
        default: ;
      endcase
    return c;
  endfunction
  function automatic logic [2:0] next_state(input logic [2:0] s, input logic [15:0] ir);
    case (s)
      3'd0: return 3'd1;
      3'd1: return 3'd2;
      3'd2: return 3'd3;
      3'd3: return (ir[15:10] == 6'h3F) ? 3'd7 : 3'd4;
      3'd4: return 3'd1;
      3'd7: return 3'd7;
      default: return 3'd0;
    endcase
  endfunction
  task automatic check(input string tag, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic step(input string tag, input logic [15:0] ir, input logic z, input logic r);
    @(negedge clock);
    reset = r;
    bus.IROut = ir;
    bus.zflag = z;
    if (r) ms = 3'd0;
    #1;
    sb.push_back(model(ms, ir, z, r));
    check($sformatf("%s s%0d", tag, ms), got, sb.pop_front());
    @(posedge clock);
    ms = r ? 3'd0 : next_state(ms, ir);
  endtask
  task automatic instr(input string tag, input logic [15:0] ir, input logic z);
    repeat (4) step(tag, ir, z, 1'b0);
  endtask
  initial begin
    bus.IROut = 16'h0000;
    bus.zflag = 1'b0;
    repeat (3) step("reset", 16'h0A5C, 1'b0, 1'b1);
    step("init", 16'h0A5C, 1'b0, 1'b0);
    instr("ldi", 16'h0A5C, 1'b0);
    instr("bne_taken", 16'h0430, 1'b0);
    instr("bne_not", 16'h0430, 1'b1);
    instr("st", 16'h1300, 1'b0);
    instr("inc", 16'h0D00, 1'b1);
    instr("nop", 16'h2800, 1'b0);
    instr("bra", 16'h0055, 1'b1);
    instr("ldi_r0", 16'h0812, 1'b0);
    repeat (3) step("halt_fetch", 16'hFC00, 1'b0, 1'b0);
    repeat (20) step("halt", 16'hFC00, 1'b0, 1'b0);
    step("halt_reset", 16'h0000, 1'b0, 1'b1);
    step("restart", 16'h0000, 1'b0, 1'b0);
    step("restart", 16'h0000, 1'b0, 1'b0);
    step("fetch_h", 16'h0000, 1'b0, 1'b0);
    @(negedge clock);
    #2;
    reset = 1'b1;
    ms = 3'd0;
    #1;
    sb.push_back(model(3'd0, 16'h0000, 1'b0, 1'b1));
    check("async_reset", got, sb.pop_front());
    @(posedge clock);
    step("async_hold", 16'h0000, 1'b0, 1'b1);
    step("after_async", 16'h0000, 1'b0, 1'b0);
    step("after_async", 16'h0000, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
